// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings understood by yAlu and the arbiter port count.
package alu_pkg;

   localparam int ALU_NPORTS = 2;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef logic [ALU_NPORTS-1:0] port_vec_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two ALU clients and alu_share_arb.
interface alu_share_arb_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
);
   port_vec_t         req_valid;
   port_vec_t         req_ready;
   logic [WIDTH-1:0]  req_a0;
   logic [WIDTH-1:0]  req_b0;
   logic [2:0]        req_op0;
   logic [WIDTH-1:0]  req_a1;
   logic [WIDTH-1:0]  req_b1;
   logic [2:0]        req_op1;
   port_vec_t         resp_valid;
   port_vec_t         resp_ready;
   logic [WIDTH-1:0]  resp_z0;
   logic [WIDTH-1:0]  resp_z1;
   logic              resp_zero0;
   logic              resp_zero1;

   modport master (
      output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
      input  req_ready, resp_valid, resp_z0, resp_z1, resp_zero0, resp_zero1
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
      output req_ready, resp_valid, resp_z0, resp_z1, resp_zero0, resp_zero1
   );

endinterface

// File: rtl/alu_share_arb_yalu.sv
// yAlu: op[1:0] selects AND/OR/arith/SLT, op[2] turns the adder into a subtractor.
module yAlu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] z,
   output logic             zero
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             slt;

   assign b_eff = op[2] ? ~b : b;
   assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, op[2]};
   // Direct signed compare rather than the adder sign bit, so overflow cannot flip SLT.
   assign slt   = $signed(a) < $signed(b);

   always_comb begin
      z = '0;
      case (op[1:0])
         2'b00:   z = a & b;
         2'b01:   z = a | b;
         2'b10:   z = sum;
         default: z = {{(WIDTH-1){1'b0}}, slt};
      endcase
   end

   assign zero = (z == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one yAlu; one registered result slot per port.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (port 0 wins ties, no rr_ptr).
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   alu_share_arb_if.slave  bus
);
   port_vec_t        elig;
   port_vec_t        grant;
   port_vec_t        slot_valid;
   port_vec_t        slot_zero;
   logic [WIDTH-1:0] slot_z [ALU_NPORTS];
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_z;
   logic             alu_zero;

   // A slot being drained this cycle can be refilled in the same cycle.
   assign elig = bus.req_valid & (~slot_valid | bus.resp_ready);

`ifdef ALU_ARB_FIXED_PRI_EN
   always_comb begin
      grant = elig;
      if (&elig) begin
         grant = 2'b01;
      end
   end
`else
   logic rr_ptr_q;
   logic rr_ptr_d;

   always_comb begin
      grant = elig;
      if (&elig) begin
         grant = rr_ptr_q ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant[0]) begin
         rr_ptr_d = 1'b1;
      end else if (grant[1]) begin
         rr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Port 0 feeds the ALU when idle; the result is simply not captured.
   assign alu_a  = grant[1] ? bus.req_a1  : bus.req_a0;
   assign alu_b  = grant[1] ? bus.req_b1  : bus.req_b0;
   assign alu_op = grant[1] ? bus.req_op1 : bus.req_op0;

   yAlu #(.WIDTH(WIDTH)) u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .op   (alu_op),
      .z    (alu_z),
      .zero (alu_zero)
   );

   genvar gi;
   generate
      for (gi = 0; gi < ALU_NPORTS; gi++) begin : gen_slot
         logic             valid_q, valid_d;
         logic             zero_q, zero_d;
         logic [WIDTH-1:0] z_q, z_d;

         always_comb begin
            valid_d = valid_q;
            zero_d  = zero_q;
            z_d     = z_q;
            if (grant[gi]) begin
               valid_d = 1'b1;
               zero_d  = alu_zero;
               z_d     = alu_z;
            end else if (valid_q && bus.resp_ready[gi]) begin
               valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               zero_q  <= 1'b0;
               z_q     <= '0;
            end else begin
               valid_q <= valid_d;
               zero_q  <= zero_d;
               z_q     <= z_d;
            end
         end

         assign slot_valid[gi] = valid_q;
         assign slot_zero[gi]  = zero_q;
         assign slot_z[gi]     = z_q;
      end
   endgenerate

   assign bus.req_ready  = grant;
   assign bus.resp_valid = slot_valid;
   assign bus.resp_z0    = slot_z[0];
   assign bus.resp_z1    = slot_z[1];
   assign bus.resp_zero0 = slot_zero[0];
   assign bus.resp_zero1 = slot_zero[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized scoreboard bench for alu_share_arb; expected results queued at grant time.
module tb_alu_share_arb;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] z;
      logic        zero;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_share_arb_if #(.WIDTH(32)) bus ();

   alu_share_arb #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   res_t exp_q [2][$];
   bit   pref = 1'b0;
   logic [1:0] granted_now = 2'b00;
   bit   mon_en = 1'b0;
   logic [2:0] op_tab [5];

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Resolution of a result slot is compared when the DUT presents and the consumer takes it.
   task automatic mon_port(input int p, input logic v, input logic rdy, input logic [31:0] z, input logic zf);
      res_t r;
      check($sformatf("resp_valid%0d", p), {63'd0, v},
            {63'd0, exp_q[p].size() > (granted_now[p] ? 1 : 0)});
      if (v && rdy) begin
         if (exp_q[p].size() == 0) begin
            check($sformatf("unexpected_resp%0d", p), {32'd0, z}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            r = exp_q[p].pop_front();
            check($sformatf("resp_z%0d", p), {32'd0, z}, {32'd0, r.z});
            check($sformatf("resp_zero%0d", p), {63'd0, zf}, {63'd0, r.zero});
            $display("cycle %0d: port %0d drained z=%0h zero=%0b", cyc, p, z, zf);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_port(0, bus.resp_valid[0], bus.resp_ready[0], bus.resp_z0, bus.resp_zero0);
         mon_port(1, bus.resp_valid[1], bus.resp_ready[1], bus.resp_z1, bus.resp_zero1);
      end
   end

   // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
   task automatic cycle(input logic [1:0] rv,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                        input logic [1:0] rr);
      logic [1:0] free, elig, exp_g;
      logic [31:0] r;
      bus.req_valid  = rv;
      bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
      bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
      bus.resp_ready = rr;
      #1;
      for (int p = 0; p < 2; p++) free[p] = (exp_q[p].size() == 0) || rr[p];
      elig  = rv & free;
      exp_g = elig;
      if (elig == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRI_EN
         exp_g = 2'b01;
`else
         exp_g = pref ? 2'b10 : 2'b01;
`endif
      end
      check("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_g});
      granted_now = exp_g;
      if (exp_g[0]) begin
         r = ref_alu(op0, a0, b0);
         exp_q[0].push_back('{z: r, zero: (r == 32'd0)});
         pref = 1'b1;
         $display("cycle %0d: grant port 0 op=%03b a=%0h b=%0h", cyc, op0, a0, b0);
      end
      if (exp_g[1]) begin
         r = ref_alu(op1, a1, b1);
         exp_q[1].push_back('{z: r, zero: (r == 32'd0)});
         pref = 1'b0;
         $display("cycle %0d: grant port 1 op=%03b a=%0h b=%0h", cyc, op1, a1, b1);
      end
      @(posedge clk);
      #1;
      granted_now = 2'b00;
      cyc++;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      pref = 1'b0;
      cyc++;
      $display("cycle %0d: reset applied", cyc);
      check("rst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
      check("rst_resp_z0", {32'd0, bus.resp_z0}, 64'd0);
      check("rst_resp_z1", {32'd0, bus.resp_z1}, 64'd0);
      check("rst_resp_zero", {62'd0, bus.resp_zero1, bus.resp_zero0}, 64'd0);
      mon_en = 1'b1;
   endtask

   initial begin
      logic [31:0] hold_z1;
      logic [1:0]  rv, rr;
      logic [31:0] a0, b0, a1, b1;
      op_tab[0] = ALU_AND; op_tab[1] = ALU_OR; op_tab[2] = ALU_ADD;
      op_tab[3] = ALU_SUB; op_tab[4] = ALU_SLT;
      rst = 1'b1;
      bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
      bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
      bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("idle_req_ready", {62'd0, bus.req_ready}, 64'd0);

      // Single ADD on port 0, visible the next cycle.
      cycle(2'b01, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 2'b01);
      check("add_valid0", {63'd0, bus.resp_valid[0]}, 64'd1);
      check("add_z0", {32'd0, bus.resp_z0}, 64'd12);
      check("add_zero0", {63'd0, bus.resp_zero0}, 64'd0);
      cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);

      // Both ports contending: strict alternation.
      repeat (8) cycle(2'b11, 32'd9, 32'd9, ALU_SUB, 32'hFFFF_FFFF, 32'd3, ALU_SLT, 2'b11);
      cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);

      // Port 1 backpressured with a full slot.
      cycle(2'b10, 0, 0, ALU_AND, 32'h1234, 32'h1111, ALU_ADD, 2'b11);
      hold_z1 = 32'h2345;
      repeat (5) begin
         cycle(2'b11, $urandom, $urandom, ALU_OR, $urandom, $urandom, ALU_ADD, 2'b01);
         check("bp_z1_stable", {32'd0, bus.resp_z1}, {32'd0, hold_z1});
      end
      cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);

      // Drain and refill port 0 in the same cycle.
      cycle(2'b01, 32'd1, 32'd1, ALU_ADD, 0, 0, ALU_AND, 2'b00);
      cycle(2'b01, 32'hF0F0, 32'h0FF0, ALU_AND, 0, 0, ALU_AND, 2'b01);
      check("refill_valid0", {63'd0, bus.resp_valid[0]}, 64'd1);
      check("refill_z0", {32'd0, bus.resp_z0}, 64'h00F0);
      cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);

      // Reset right after a port 0 grant; a tie afterwards goes to port 0.
      cycle(2'b01, 32'd3, 32'd4, ALU_ADD, 0, 0, ALU_AND, 2'b00);
      do_reset();
      cycle(2'b11, 32'd2, 32'd2, ALU_SUB, 32'd6, 32'd1, ALU_OR, 2'b11);
      cycle(2'b11, 32'd2, 32'd2, ALU_SUB, 32'd6, 32'd1, ALU_OR, 2'b11);
      cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);

      // Randomized traffic with occasional mid-stream resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            rv = 2'($urandom);
            rr = 2'($urandom_range(0, 3) == 0 ? $urandom : 2'b11);
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            cycle(rv, a0, b0, op_tab[$urandom_range(0, 4)],
                  a1, b1, op_tab[$urandom_range(0, 4)], rr);
         end
      end

      repeat (2) cycle(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 2'b11);
      check("final_q0_empty", 64'(exp_q[0].size()), 64'd0);
      check("final_q1_empty", 64'(exp_q[1].size()), 64'd0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
